// File: rtl/mimsr_pkg.sv
// Shared constants and response entry type for the system-information responder.
package mimsr_pkg;

    localparam int unsigned MIMSR_IDX_MEMSIZE = 32'd0;
    localparam int unsigned MIMSR_IDX_DEVID   = 32'd1;
    localparam int unsigned MIMSR_IDX_CORES   = 32'd2;
    localparam int unsigned MIMSR_IDX_FEATURE = 32'd3;
    localparam int unsigned MIMSR_IDX_CYC_LO  = 32'd4;
    localparam int unsigned MIMSR_IDX_CYC_HI  = 32'd5;

    localparam int unsigned MIMSR_FEAT_CYCLE  = 32'd0;

    localparam int unsigned MIMSR_RESP_W      = 32'd33;

    typedef struct packed {
        logic        error;
        logic [31:0] data;
    } mimsr_resp_t;

endpackage

// File: rtl/mimsr_sysinfo_if.sv
// Request/response bus of the system-information responder; master = CPU side, slave = device.
interface mimsr_sysinfo_if #(
    parameter int P_ADDR_W = 4
);
    logic                iREQ_VALID;
    logic [P_ADDR_W-1:0] iREQ_ADDR;
    logic                oREQ_BUSY;
    logic                oRESP_VALID;
    logic [31:0]         oRESP_DATA;
    logic                oRESP_ERROR;
    logic                iRESP_BUSY;

    modport master (
        output iREQ_VALID, iREQ_ADDR, iRESP_BUSY,
        input  oREQ_BUSY, oRESP_VALID, oRESP_DATA, oRESP_ERROR
    );

    modport slave (
        input  iREQ_VALID, iREQ_ADDR, iRESP_BUSY,
        output oREQ_BUSY, oRESP_VALID, oRESP_DATA, oRESP_ERROR
    );
endinterface

// File: rtl/mimsr_resp_fifo.sv
// Generic synchronous show-ahead FIFO; head data reads as zero while empty.
module mimsr_resp_fifo #(
    parameter int P_WIDTH = 33,
    parameter int P_DEPTH = 4
) (
    input  logic                         iCLOCK,
    input  logic                         iRESET_SYNC,
    input  logic                         iPUSH,
    input  logic [P_WIDTH-1:0]           iDATA,
    input  logic                         iPOP,
    output logic [P_WIDTH-1:0]           oDATA,
    output logic                         oFULL,
    output logic                         oEMPTY,
    output logic [$clog2(P_DEPTH):0]     oCOUNT
);
    localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CNT_W = $clog2(P_DEPTH) + 1;

    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic [PTR_W-1:0]   wrPtr_r;
    logic [PTR_W-1:0]   rdPtr_r;
    logic [CNT_W-1:0]   count_r;
    logic               pushEn_s;
    logic               popEn_s;

    assign oFULL    = (count_r == CNT_W'(P_DEPTH));
    assign oEMPTY   = (count_r == {CNT_W{1'b0}});
    assign oCOUNT   = count_r;
    assign pushEn_s = iPUSH & ~oFULL;
    assign popEn_s  = iPOP & ~oEMPTY;
    assign oDATA    = oEMPTY ? {P_WIDTH{1'b0}} : mem_r[rdPtr_r];

    // Storage and pointers; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_r[i] <= {P_WIDTH{1'b0}};
            end
        end else begin
            if (pushEn_s) begin
                mem_r[wrPtr_r] <= iDATA;
                wrPtr_r        <= wrPtr_r + PTR_W'(1);
            end
            if (popEn_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy count.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({pushEn_s, popEn_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mimsr_sysinfo.sv
// Indexed system-information responder with queued responses.
// Optional 64-bit cycle counter enabled by defining MIMSR_CYCLE_COUNTER_EN.
module mimsr_sysinfo
    import mimsr_pkg::*;
#(
    parameter int          P_ADDR_W     = 4,
    parameter int          P_FIFO_DEPTH = 4,
    parameter logic [31:0] P_MEM_SIZE   = 32'h0400_0000,
    parameter logic [31:0] P_DEVICE_ID  = 32'h1032_0001,
    parameter logic [31:0] P_CORE_COUNT = 32'h0000_0001
) (
    input  logic            iCLOCK,
    input  logic            iRESET_SYNC,
    mimsr_sysinfo_if.slave  bus
);
    localparam int CNT_W = $clog2(P_FIFO_DEPTH) + 1;
`ifdef MIMSR_CYCLE_COUNTER_EN
    localparam logic [31:0] FEATURE_VAL = 32'h0000_0001 << MIMSR_FEAT_CYCLE;
`else
    localparam logic [31:0] FEATURE_VAL = 32'h0000_0000;
`endif

    logic             accept_s;
    logic             pop_s;
    logic             busy_s;
    logic             fifoFull_s;
    logic             fifoEmpty_s;
    logic [CNT_W-1:0] fifoCount_s;
    mimsr_resp_t      lookup_s;
    mimsr_resp_t      head_s;

    assign busy_s   = (fifoCount_s == CNT_W'(P_FIFO_DEPTH));
    assign accept_s = bus.iREQ_VALID & ~busy_s;
    assign pop_s    = ~fifoEmpty_s & ~bus.iRESP_BUSY;

    assign bus.oREQ_BUSY   = busy_s;
    assign bus.oRESP_VALID = ~fifoEmpty_s;
    assign bus.oRESP_DATA  = head_s.data;
    assign bus.oRESP_ERROR = head_s.error;

`ifdef MIMSR_CYCLE_COUNTER_EN
    logic [63:0] cycleCnt_r;
    logic [31:0] cycleSnap_r;

    // Free-running cycle counter; a CYC_LO read captures the upper half for a later CYC_HI read.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            cycleCnt_r  <= 64'h0;
            cycleSnap_r <= 32'h0;
        end else begin
            cycleCnt_r <= cycleCnt_r + 64'h1;
            if (accept_s && (bus.iREQ_ADDR == P_ADDR_W'(MIMSR_IDX_CYC_LO))) begin
                cycleSnap_r <= cycleCnt_r[63:32];
            end else begin
                cycleSnap_r <= cycleSnap_r;
            end
        end
    end
`endif

    // Register-map lookup; anything not mapped answers zero with error set.
    always_comb begin
        lookup_s = '{error: 1'b1, data: 32'h0};
        case (bus.iREQ_ADDR)
            P_ADDR_W'(MIMSR_IDX_MEMSIZE): lookup_s = '{error: 1'b0, data: P_MEM_SIZE};
            P_ADDR_W'(MIMSR_IDX_DEVID):   lookup_s = '{error: 1'b0, data: P_DEVICE_ID};
            P_ADDR_W'(MIMSR_IDX_CORES):   lookup_s = '{error: 1'b0, data: P_CORE_COUNT};
            P_ADDR_W'(MIMSR_IDX_FEATURE): lookup_s = '{error: 1'b0, data: FEATURE_VAL};
`ifdef MIMSR_CYCLE_COUNTER_EN
            P_ADDR_W'(MIMSR_IDX_CYC_LO):  lookup_s = '{error: 1'b0, data: cycleCnt_r[31:0]};
            P_ADDR_W'(MIMSR_IDX_CYC_HI):  lookup_s = '{error: 1'b0, data: cycleSnap_r};
`endif
            default:                      lookup_s = '{error: 1'b1, data: 32'h0};
        endcase
    end

    mimsr_resp_fifo #(
        .P_WIDTH (MIMSR_RESP_W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iPUSH       (accept_s & ~fifoFull_s),
        .iDATA       (lookup_s),
        .iPOP        (pop_s),
        .oDATA       (head_s),
        .oFULL       (fifoFull_s),
        .oEMPTY      (fifoEmpty_s),
        .oCOUNT      (fifoCount_s)
    );

endmodule

// File: tb/tb_mimsr_sysinfo.sv
// Self-checking bench for mimsr_sysinfo: vector table, corner sequences, randomized traffic vs. queue model.
module tb_mimsr_sysinfo;

    localparam int DEPTH = 4;
`ifdef MIMSR_CYCLE_COUNTER_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif
    localparam logic [31:0] FEAT = CYC_EN ? 32'h1 : 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mimsr_sysinfo_if #(.P_ADDR_W(4)) bus ();

    mimsr_sysinfo dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    logic [32:0]     mq[$];
    longint unsigned mCnt  = 0;
    logic [31:0]     mSnap = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Register map as the device documents it; mCnt/mSnap are the values at the accept cycle.
    function automatic logic [32:0] mdl_read(input int unsigned idx);
        case (idx)
            0: return {1'b0, 32'h0400_0000};
            1: return {1'b0, 32'h1032_0001};
            2: return {1'b0, 32'h0000_0001};
            3: return {1'b0, FEAT};
            4: return CYC_EN ? {1'b0, mCnt[31:0]} : {1'b1, 32'h0};
            5: return CYC_EN ? {1'b0, mSnap} : {1'b1, 32'h0};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic set_in(input bit v, input int unsigned a, input bit rb);
        bus.iREQ_VALID = v;
        bus.iREQ_ADDR  = 4'(a);
        bus.iRESP_BUSY = rb;
    endtask

    // Advance one clock with the inputs already applied, update the model, then compare.
    task automatic cycle();
        bit          acc;
        bit          pp;
        logic [32:0] e;
        logic [32:0] hd;
        acc = bus.iREQ_VALID && (mq.size() != DEPTH);
        pp  = (mq.size() != 0) && !bus.iRESP_BUSY;
        if (rst) begin
            mq.delete();
            mCnt  = 0;
            mSnap = 32'h0;
        end else begin
            e = mdl_read(int'(bus.iREQ_ADDR));
            if (acc && bus.iREQ_ADDR == 4'd4) mSnap = mCnt[63:32];
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            mCnt = mCnt + 1;
        end
        @(posedge clk);
        @(negedge clk);
        hd = (mq.size() != 0) ? mq[0] : 33'h0;
        chk("mdl_busy",  {63'h0, bus.oREQ_BUSY},   {63'h0, mq.size() == DEPTH});
        chk("mdl_valid", {63'h0, bus.oRESP_VALID}, {63'h0, mq.size() != 0});
        chk("mdl_data",  {32'h0, bus.oRESP_DATA},  {32'h0, hd[31:0]});
        chk("mdl_err",   {63'h0, bus.oRESP_ERROR}, {63'h0, hd[32]});
    endtask

    typedef struct {
        bit          v;
        int unsigned addr;
        bit          rb;
        bit          eValid;
        logic [31:0] eData;
        bit          eErr;
        bit          eBusy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 0,  1'b0, 1'b1, 32'h0400_0000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 9,  1'b0, 1'b1, 32'h0,         1'b1, 1'b0};
        tbl[2] = '{1'b1, 3,  1'b0, 1'b1, FEAT,          1'b0, 1'b0};
        tbl[3] = '{1'b1, 1,  1'b0, 1'b1, 32'h1032_0001, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2,  1'b0, 1'b1, 32'h1,         1'b0, 1'b0};
        tbl[5] = '{1'b1, 15, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0};
        tbl[6] = '{1'b1, 5,  1'b0, 1'b1, 32'h0,         !CYC_EN, 1'b0};
        tbl[7] = '{1'b0, 0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0};

        set_in(1'b0, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_valid", {63'h0, bus.oRESP_VALID}, 64'h0);
        chk("rst_busy",  {63'h0, bus.oREQ_BUSY},   64'h0);
        chk("rst_data",  {32'h0, bus.oRESP_DATA},  64'h0);
        chk("rst_err",   {63'h0, bus.oRESP_ERROR}, 64'h0);

        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].v, tbl[i].addr, tbl[i].rb);
            cycle();
            chk($sformatf("tbl%0d_valid", i), {63'h0, bus.oRESP_VALID}, {63'h0, tbl[i].eValid});
            chk($sformatf("tbl%0d_data", i),  {32'h0, bus.oRESP_DATA},  {32'h0, tbl[i].eData});
            chk($sformatf("tbl%0d_err", i),   {63'h0, bus.oRESP_ERROR}, {63'h0, tbl[i].eErr});
            chk($sformatf("tbl%0d_busy", i),  {63'h0, bus.oREQ_BUSY},   {63'h0, tbl[i].eBusy});
        end

        // Fill under consumer stall, hold a fifth request, release with a full-cycle pop.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, i, 1'b1);
            cycle();
        end
        chk("full_busy", {63'h0, bus.oREQ_BUSY}, 64'h1);
        set_in(1'b1, 1, 1'b1);
        cycle();
        chk("held_busy", {63'h0, bus.oREQ_BUSY}, 64'h1);
        chk("held_head", {32'h0, bus.oRESP_DATA}, 64'h0400_0000);
        set_in(1'b1, 1, 1'b0);
        cycle();
        chk("fullpop_busy", {63'h0, bus.oREQ_BUSY}, 64'h0);
        chk("fullpop_head", {32'h0, bus.oRESP_DATA}, 64'h1032_0001);
        set_in(1'b1, 1, 1'b1);
        cycle();
        chk("late_accept_busy", {63'h0, bus.oREQ_BUSY}, 64'h1);
        set_in(1'b0, 0, 1'b0);
        chk("order0", {32'h0, bus.oRESP_DATA}, 64'h1032_0001);
        cycle();
        chk("order1", {32'h0, bus.oRESP_DATA}, 64'h1);
        cycle();
        chk("order2", {32'h0, bus.oRESP_DATA}, {32'h0, FEAT});
        cycle();
        chk("order3", {32'h0, bus.oRESP_DATA}, 64'h1032_0001);
        cycle();
        chk("drained", {63'h0, bus.oRESP_VALID}, 64'h0);

        // Reset with entries queued and a request pending.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, i, 1'b1);
            cycle();
        end
        set_in(1'b1, 0, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst6_valid", {63'h0, bus.oRESP_VALID}, 64'h0);
        chk("rst6_busy",  {63'h0, bus.oREQ_BUSY},   64'h0);
        chk("rst6_data",  {32'h0, bus.oRESP_DATA},  64'h0);
        set_in(1'b1, 4, 1'b0);
        cycle();
        chk("rst6_cyc_data", {32'h0, bus.oRESP_DATA},  64'h0);
        chk("rst6_cyc_err",  {63'h0, bus.oRESP_ERROR}, {63'h0, !CYC_EN});
        set_in(1'b0, 0, 1'b0);
        cycle();

`ifdef MIMSR_CYCLE_COUNTER_EN
        // Counter split across the 32-bit boundary, then across the 64-bit wrap.
        force dut.cycleCnt_r = 64'h0000_0001_FFFF_FFFE;
        #1 release dut.cycleCnt_r;
        mCnt = 64'h0000_0001_FFFF_FFFE;
        set_in(1'b1, 4, 1'b0);
        cycle();
        chk("cyc_lo", {32'h0, bus.oRESP_DATA}, 64'hFFFF_FFFE);
        set_in(1'b1, 5, 1'b0);
        cycle();
        chk("cyc_hi", {32'h0, bus.oRESP_DATA}, 64'h1);
        set_in(1'b0, 0, 1'b0);
        cycle();
        force dut.cycleCnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.cycleCnt_r;
        mCnt = 64'hFFFF_FFFF_FFFF_FFFF;
        set_in(1'b1, 4, 1'b0);
        cycle();
        chk("wrap_lo", {32'h0, bus.oRESP_DATA}, 64'hFFFF_FFFF);
        chk("wrap_cnt", dut.cycleCnt_r, 64'h0);
        set_in(1'b1, 5, 1'b0);
        cycle();
        chk("wrap_hi", {32'h0, bus.oRESP_DATA}, 64'hFFFF_FFFF);
        set_in(1'b0, 0, 1'b0);
        cycle();
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_in($urandom_range(0, 2) != 0, $urandom_range(0, 15),
                   $urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 2 : 7));
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
